memory_lsu: RTL
===============

MEMORY_LSU -- requirements
Module: memory_lsu

Interface
REQ-001 SHALL have parameter WORD, default 32, meaning datapath width in bits.
REQ-002 SHALL have parameter REG_SIZE, default 5, meaning register-index width.
REQ-003 SHALL have parameter DMEM_POWER, default 18, meaning log2 of data-memory depth in words.
REQ-004 SHALL have parameter WAIT_CYCLES, default 0, range 0..15, meaning stall cycles per aligned memory access.
REQ-005 SHALL have ports:
  clk  in  1  clock, rising edge
  reset  in  1  asynchronous, active-low
  writeDataM  in  WORD  store data
  ALUResultM  in  WORD  byte address, or passthrough result
  writeRegM  in  REG_SIZE  destination register
  regWriteM  in  1  register-write enable
  memWriteM  in  1  store request
  mem2regM  in  1  load request, selects memory data at W
  sizeM  in  2  00 byte, 01 half, 10 word, 11 treated as word
  unsignedM  in  1  zero-extend loads when 1, sign-extend when 0
  zeroM  in  1  ALU zero flag
  branchM  in  1  branch instruction
  readDataW  out  WORD  aligned, extended load data
  ALUResultW  out  WORD  registered ALUResultM
  writeRegW  out  REG_SIZE  registered writeRegM
  regWriteW  out  1  registered, qualified regWriteM
  mem2regW  out  1  registered mem2regM
  excW  out  1  misaligned-access flag
  PCSrcM  out  1  branch taken
  stallM  out  1  hold upstream stages

Function
REQ-006 SHALL compute PCSrcM = zeroM AND branchM combinationally, independent of stall.
REQ-007 SHALL index memory with word address ALUResultM[DMEM_POWER+1:2] and read it asynchronously.
REQ-008 SHALL define an access as memWriteM=1 or mem2regM=1.
REQ-009 SHALL flag a misaligned access when half with addr[0]=1, or word with addr[1:0]!=0.
REQ-010 SHALL write byte stores from writeDataM[7:0] into lane addr[1:0] only; other lanes unchanged.
REQ-011 SHALL write half stores from writeDataM[15:0] into lanes {addr[1],0} and {addr[1],1} only.
REQ-012 SHALL write word stores as the full word.
REQ-013 SHALL extract byte/half load data from the addressed lane and extend it to WORD per unsignedM.
REQ-014 SHALL give misaligned accesses zero stall cycles; suppress the memory write; register readDataW=0, regWriteW=0, excW=1.
REQ-015 SHALL implement FSM states IDLE and WAIT, with a 4-bit counter cnt.
REQ-016 SHALL, in IDLE with an aligned access and WAIT_CYCLES>0, assert stallM, enter WAIT, and set cnt=1.
REQ-017 SHALL, in WAIT, deassert stallM and return to IDLE when cnt==WAIT_CYCLES; otherwise assert stallM and increment cnt.
REQ-018 SHALL complete the access in the first cycle with stallM=0; the store commits and the W register captures at that cycle's clock edge.
REQ-019 SHALL assert stallM for exactly WAIT_CYCLES cycles per aligned access; with WAIT_CYCLES=0, stallM SHALL stay 0.
REQ-020 SHALL treat M inputs as held stable by upstream while stallM=1; the block SHALL NOT re-sample them mid-access.
REQ-021 SHALL load a bubble into the W register on every edge where stallM=1: regWriteW=0, mem2regW=0, excW=0.
REQ-022 SHALL commit a store exactly once per access, never during stall cycles.
REQ-023 SHALL pass non-access instructions through in one cycle with no stall, whatever the FSM state history.
REQ-024 SHALL let an access presented in the cycle after a completion start a fresh IDLE->WAIT sequence with no idle gap.
REQ-025 SHALL register all W outputs, excW included, through one pipeline register.

Reset
REQ-026 SHALL, while reset=0 and regardless of clk, drive all W outputs to 0, FSM to IDLE, cnt to 0, and stallM to 0.
REQ-027 SHALL, on reset mid-WAIT, discard the pending store without modifying memory.
REQ-028 SHALL NOT reset memory contents.

Verification
REQ-029 WAIT_CYCLES=0: store word 0xDEADBEEF to 0x10, then load word with writeRegM=3 -> next cycle readDataW=0xDEADBEEF, regWriteW=1, writeRegW=3, stallM never 1.
REQ-030 Word 0x11223344 at 0x20: load byte 0x23 signed -> 0x00000011; store byte 0x80 to 0x21, load byte 0x21 signed -> 0xFFFFFF80; unsigned -> 0x00000080; load word 0x20 -> 0x11228044.
REQ-031 WAIT_CYCLES=3, store then load: stallM high exactly 3 cycles per access, W shows bubbles during stall, single write observed, load returns stored value.
REQ-032 Half store to 0x13 and word load from 0x22: excW=1, regWriteW=0, readDataW=0, stallM=0, memory unchanged.
REQ-033 WAIT_CYCLES=4, assert reset=0 asynchronously at cnt=2 of a store -> outputs 0 immediately, target word unchanged, next access stalls a full 4 cycles.
REQ-034 zeroM=1, branchM=1 during a stall -> PCSrcM=1 in the same cycle; zeroM=0 -> PCSrcM=0.

Source files
------------

// File: rtl/memory_lsu_if.sv
// Memory-stage bus for memory_lsu: M-stage request fields in, W-stage results,
// branch decision and stall out.
interface memory_lsu_if #(
    parameter int WORD     = 32,
    parameter int REG_SIZE = 5
);
    logic [WORD-1:0]     writeDataM;
    logic [WORD-1:0]     ALUResultM;
    logic [REG_SIZE-1:0] writeRegM;
    logic                regWriteM;
    logic                memWriteM;
    logic                mem2regM;
    logic [1:0]          sizeM;
    logic                unsignedM;
    logic                zeroM;
    logic                branchM;

    logic [WORD-1:0]     readDataW;
    logic [WORD-1:0]     ALUResultW;
    logic [REG_SIZE-1:0] writeRegW;
    logic                regWriteW;
    logic                mem2regW;
    logic                excW;
    logic                PCSrcM;
    logic                stallM;

    modport master (
        output writeDataM, ALUResultM, writeRegM, regWriteM, memWriteM, mem2regM,
               sizeM, unsignedM, zeroM, branchM,
        input  readDataW, ALUResultW, writeRegW, regWriteW, mem2regW, excW,
               PCSrcM, stallM
    );

    modport slave (
        input  writeDataM, ALUResultM, writeRegM, regWriteM, memWriteM, mem2regM,
               sizeM, unsignedM, zeroM, branchM,
        output readDataW, ALUResultW, writeRegW, regWriteW, mem2regW, excW,
               PCSrcM, stallM
    );
endinterface

// File: rtl/memory_lsu.sv
// Memory stage: byte/half/word load-store with alignment check, configurable
// wait states and the M->W pipeline register.
module memory_lsu #(
    parameter int WORD        = 32,
    parameter int REG_SIZE    = 5,
    parameter int DMEM_POWER  = 18,
    parameter int WAIT_CYCLES = 0
) (
    input  logic         clk,
    input  logic         reset,
    memory_lsu_if.slave  bus
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t                state, state_nx;
    logic [3:0]            cnt, cnt_nx;
    logic [WORD-1:0]       mem [0:(1<<DMEM_POWER)-1];
    logic [DMEM_POWER-1:0] waddr;
    logic [1:0]            lane;
    logic [WORD-1:0]       rdata, wmerged, ldata;
    logic [7:0]            bval;
    logic [15:0]           hval;
    logic                  access, mis_addr, mis, aligned_acc, stall, store_en;

    assign waddr       = bus.ALUResultM[DMEM_POWER+1:2];
    assign lane        = bus.ALUResultM[1:0];
    assign rdata       = mem[waddr];
    assign access      = bus.memWriteM | bus.mem2regM;
    assign mis         = access & mis_addr;
    assign aligned_acc = access & ~mis_addr;
    assign bus.PCSrcM  = bus.zeroM & bus.branchM;
    assign bus.stallM  = stall;

    always_comb begin
        case (bus.sizeM)
            2'b00:   mis_addr = 1'b0;
            2'b01:   mis_addr = bus.ALUResultM[0];
            default: mis_addr = (bus.ALUResultM[1:0] != 2'b00);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (aligned_acc && WAIT_CYCLES != 0) begin
                state_nx = WAIT;
                cnt_nx   = 4'd1;
            end
            WAIT: if (cnt == 4'(WAIT_CYCLES)) begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end else begin
                cnt_nx   = cnt + 4'd1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Gated by reset so the async clear also drops stall while inputs are live.
    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = aligned_acc && (WAIT_CYCLES != 0);
            WAIT:    stall = (cnt != 4'(WAIT_CYCLES));
            default: stall = 1'b0;
        endcase
        stall = stall & reset;
    end

    // Partial stores are read-modify-write on the asynchronously read word.
    always_comb begin
        wmerged = rdata;
        case (bus.sizeM)
            2'b00:   wmerged[{lane, 3'b000} +: 8]     = bus.writeDataM[7:0];
            2'b01:   wmerged[{lane[1], 4'b0000} +: 16] = bus.writeDataM[15:0];
            default: wmerged = bus.writeDataM;
        endcase
    end

    assign store_en = reset & bus.memWriteM & ~mis_addr & ~stall;

    always_ff @(posedge clk) begin
        if (store_en)
            mem[waddr] <= wmerged;
    end

    always_comb begin
        bval = rdata[{lane, 3'b000} +: 8];
        hval = rdata[{lane[1], 4'b0000} +: 16];
        case (bus.sizeM)
            2'b00:   ldata = bus.unsignedM ? WORD'(bval) : WORD'($signed(bval));
            2'b01:   ldata = bus.unsignedM ? WORD'(hval) : WORD'($signed(hval));
            default: ldata = rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset || stall) begin
            bus.readDataW  <= '0;
            bus.ALUResultW <= '0;
            bus.writeRegW  <= '0;
            bus.regWriteW  <= 1'b0;
            bus.mem2regW   <= 1'b0;
            bus.excW       <= 1'b0;
        end else begin
            bus.readDataW  <= mis ? '0 : ldata;
            bus.ALUResultW <= bus.ALUResultM;
            bus.writeRegW  <= bus.writeRegM;
            bus.regWriteW  <= bus.regWriteM & ~mis;
            bus.mem2regW   <= bus.mem2regM;
            bus.excW       <= mis;
        end
    end
endmodule
